debug_event_queue: RTL

DEBUG_EVENT_QUEUE -- requirements
Module: debug_event_queue

---
 rtl/visumon_pkg.sv | 38 +++
 rtl/dbg_fifo.sv | 90 +++++++++
 rtl/debug_event_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/visumon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : visumon_pkg
//  Description : Types shared by the visuMon display monitor and its debug
//                event front-end: the LED colour enum, the 19-bit debug info
//                payload and the debug event queue FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package visumon_pkg;

    // LED colour, 3 bits; every encoding is a legal colour.
    typedef enum logic [2:0] {
        COLOR_OFF     = 3'd0,
        COLOR_RED     = 3'd1,
        COLOR_GREEN   = 3'd2,
        COLOR_BLUE    = 3'd3,
        COLOR_YELLOW  = 3'd4,
        COLOR_CYAN    = 3'd5,
        COLOR_MAGENTA = 3'd6,
        COLOR_WHITE   = 3'd7
    } color_t;

    // Debug payload shown on visuMon: 8 + 3 + 8 = 19 bits.
    typedef struct packed {
        logic [7:0] ledNo;
        color_t     color;
        logic [7:0] status;
    } debugInfo_t;

    // Debug event queue presentation FSM.
    typedef enum logic [1:0] {
        DBGQ_IDLE = 2'd0,
        DBGQ_SHOW = 2'd1,
        DBGQ_GAP  = 2'd2
    } dbgq_state_t;

endpackage
`default_nettype wire

// File: rtl/dbg_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_fifo
//  Description : DEPTH-entry FIFO of debugInfo_t. Pointers wrap modulo DEPTH
//                (DEPTH is a power of two) and a separate count 0..DEPTH
//                distinguishes full from empty. A push while full and a pop
//                while empty are ignored. Push and pop on the same edge both
//                take effect and leave the count unchanged.
//  Ports       : i_clkSys, i_reset (sync, active-high)
//                i_push/i_data  - write request and payload
//                i_pop          - remove head
//                o_data         - current head (valid when !o_empty)
//                o_full/o_empty - registered-count flags
//                o_count        - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module dbg_fifo
    import visumon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clkSys,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  debugInfo_t               i_data,
    input  logic                     i_pop,
    output debugInfo_t               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    debugInfo_t         mem_q [DEPTH];
    debugInfo_t         mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               push_ok;
    logic               pop_ok;

    assign o_full  = (cnt_q == CNT_W'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign o_count = cnt_q;
    assign o_data  = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a simultaneous pop never
    // makes room for a push on the same edge.
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop  && !o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clkSys) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : debug_event_queue
//  Description : Buffers debug events and presents them one at a time to
//                visuMon. Each entry is shown (o_csVisuMon low) for
//                DWELL_CYCLES clocks; back-to-back entries are separated by a
//                single deselected gap cycle. Events arriving while the FIFO
//                is full are dropped and flagged in a sticky overflow bit.
//  Ports       : i_clkSys, i_reset (sync, active-high)
//                i_evValid/i_evInfo - producer event
//                o_evReady          - FIFO not full
//                o_debugInfo        - payload to visuMon i_debugInfo
//                o_csVisuMon        - active-low select to visuMon i_cs
//                o_pending          - queued entries, excluding the shown one
//                o_overflow         - sticky dropped-event flag
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_event_queue
    import visumon_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int DWELL_CYCLES = 10000000
) (
    input  logic                   i_clkSys,
    input  logic                   i_reset,
    input  logic                   i_evValid,
    input  debugInfo_t             i_evInfo,
    output logic                   o_evReady,
    output debugInfo_t             o_debugInfo,
    output logic                   o_csVisuMon,
    output logic [$clog2(DEPTH):0] o_pending,
    output logic                   o_overflow
);

    localparam int                 DWELL_W    = $clog2(DWELL_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    dbgq_state_t        state_q, state_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    debugInfo_t         info_q, info_d;
    logic               cs_q, cs_d;
    logic               ovf_q, ovf_d;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    debugInfo_t         fifo_head;

    dbg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clkSys (i_clkSys),
        .i_reset  (i_reset),
        .i_push   (i_evValid),
        .i_data   (i_evInfo),
        .i_pop    (fifo_pop),
        .o_data   (fifo_head),
        .o_full   (fifo_full),
        .o_empty  (fifo_empty),
        .o_count  (o_pending)
    );

    assign o_evReady   = !fifo_full;
    assign o_debugInfo = info_q;
    assign o_csVisuMon = cs_q;
    assign o_overflow  = ovf_q;

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        info_d   = info_q;
        cs_d     = cs_q;
        fifo_pop = 1'b0;
        ovf_d    = ovf_q | (i_evValid & fifo_full);

        case (state_q)
            // IDLE and GAP both load the head as soon as one is available;
            // they differ only in how they were entered.
            DBGQ_IDLE, DBGQ_GAP: begin
                cs_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    info_d   = fifo_head;
                    cs_d     = 1'b0;
                    dwell_d  = '0;
                    state_d  = DBGQ_SHOW;
                end else begin
                    state_d  = DBGQ_IDLE;
                end
            end
            DBGQ_SHOW: begin
                cs_d = 1'b0;
                if (dwell_q == DWELL_LAST) begin
                    cs_d    = 1'b1;
                    state_d = fifo_empty ? DBGQ_IDLE : DBGQ_GAP;
                end else begin
                    // Counter stops at DWELL_LAST, so it can never wrap.
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = DBGQ_IDLE;
                cs_d    = 1'b1;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clkSys) begin
        if (i_reset) begin
            state_q <= DBGQ_IDLE;
            dwell_q <= '0;
            info_q  <= '0;
            cs_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            info_q  <= info_d;
            cs_q    <= cs_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
`default_nettype wire
